edgegen: RTL and testbench
==========================

EDGEGEN -- requirements
Module: edgegen

Interface
REQ-001 Parameter e, default "pos": active level of async; "pos" means idle 0 and active 1, any other value means idle 1 and active 0.
REQ-002 Parameter HI, default 4: cycles async is held active per pulse; legal range 1..255.
REQ-003 Parameter LO, default 4: minimum cycles async is held idle between pulses; legal range 1..255.
REQ-004 Parameter PW, default 4: width of the pending-request counter.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 trig  input  1  single-cycle request, synchronous to clk; one pulse per asserted cycle.
REQ-008 async  output  1  registered stretched pulse, driven to a foreign clock domain that samples it with an edge synchronizer.
REQ-009 busy  output  PW-wide? no: 1  high whenever state is not IDLE.
REQ-010 pending  output  PW  count of accepted requests not yet launched.
REQ-011 overflow  output  1  sticky flag, set when a request is dropped.

Function
REQ-012 FSM states: IDLE, HIGH, LOW; one cycle counter (width 8) is shared by HIGH and LOW.
REQ-013 IDLE: if trig=1 or pending>0, the next state is HIGH and the counter loads HI-1; otherwise the FSM stays in IDLE.
REQ-014 HIGH: async is at the active level; when the counter reaches 0, the next state is LOW and the counter loads LO-1; otherwise the counter decrements.
REQ-015 LOW: async is idle; when the counter reaches 0, the next state is HIGH (counter loads HI-1) if trig=1 or pending>0, else IDLE; otherwise the counter decrements.
REQ-016 Launch: the cycle the FSM enters HIGH; latency is trig at cycle N in IDLE -> async active from cycle N+1 for exactly HI cycles.
REQ-017 Launch source: pending>0 takes priority over trig; a launch with pending>0 consumes one pending request.
REQ-018 Pending update per cycle: +1 if trig was not the launch source; -1 if pending was the launch source. A simultaneous +1 and -1 leaves pending unchanged.
REQ-019 When pending equals 2^PW-1 and an increment is required, pending holds, the request is dropped, and overflow is set to 1 on the next cycle until reset.
REQ-020 Two consecutive launches are always separated by at least LO idle cycles; back-to-back launches form a period of exactly HI+LO cycles.
REQ-021 async, busy, pending and overflow are driven directly from registers; none has a combinational path from trig.
REQ-022 busy is 1 in HIGH and LOW, and 0 in IDLE.

Reset
REQ-023 rst_n=0 sampled at posedge clk: state becomes IDLE, the counter 0, pending 0, overflow 0, busy 0, async the idle level.
REQ-024 Reset mid-pulse: async returns to the idle level on the same edge; in-flight and pending requests are discarded.
REQ-025 trig is ignored on any cycle where rst_n=0.

Structure
REQ-026 The state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) and the counter width constant reside in the shared definitions package edgegen_pkg.
REQ-027 One sub-module, cyccnt (loadable 8-bit down counter with a zero flag), implements the HIGH/LOW timer; the FSM and pending logic are in edgegen.

Verification
REQ-028 Defaults, e="pos": single trig at cycle 10 -> async=1 on cycles 11-14, 0 from cycle 15; busy=1 on cycles 11-18; IDLE at cycle 19.
REQ-029 e="neg": same stimulus -> async=0 on cycles 11-14, 1 otherwise.
REQ-030 Defaults: trig on cycles 10, 11, 12 -> pending peaks at 2; pulses start at cycles 11, 19, 27, each 4 cycles long; pending=0 by cycle 28.
REQ-031 PW=2: trig on 5 consecutive cycles starting in IDLE -> first launches, pending saturates at 3, the fifth trig is dropped, overflow=1 sticky, exactly 4 pulses emitted.
REQ-032 Defaults: trig on the last LOW cycle with pending=0 -> HIGH on the next cycle, pending stays 0; trig on that cycle with pending=1 -> pending stays 1.
REQ-033 rst_n=0 during cycle 2 of HIGH with pending=2 -> next cycle async idle, pending=0, busy=0; no further pulses after release.

Source files
------------

// File: rtl/edgegen_pkg.sv
// Shared definitions for the edge generator: FSM encoding, timer width,
// and the small control bundles passed between FSM and timer.
package edgegen_pkg;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic go;
    logic from_pend;
  } launch_t;

  typedef struct packed {
    logic          load;
    logic          dec;
    logic [CW-1:0] val;
  } cnt_ctl_t;

  // Counter reload value for a phase lasting n cycles (counter runs n-1 .. 0).
  function automatic logic [CW-1:0] ld_val(input int n);
    return CW'(n - 1);
  endfunction
endpackage

// File: rtl/cyccnt.sv
// Loadable down counter with zero flag; times the HIGH and LOW phases.
module cyccnt
  import edgegen_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  cnt_ctl_t ctl,
  output logic     zero
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                   cnt <= '0;
    else if (ctl.load)            cnt <= ctl.val;
    else if (ctl.dec && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/edgegen.sv
// Stretches single-cycle trig requests into HI-cycle pulses separated by at
// least LO idle cycles, queueing requests that arrive while a pulse is busy.
module edgegen
  import edgegen_pkg::*;
#(
  parameter string e  = "pos",
  parameter int    HI = 4,
  parameter int    LO = 4,
  parameter int    PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  output logic          async,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);
  localparam logic          ACT   = (e == "pos");
  localparam logic [CW-1:0] HI_LD = ld_val(HI);
  localparam logic [CW-1:0] LO_LD = ld_val(LO);

  state_t   state, nstate;
  launch_t  lnc;
  cnt_ctl_t ctl;
  logic     zero, has_req;
  logic     async_d, busy_d;
  logic     inc, dec, full;

  cyccnt u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (ctl),
    .zero (zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate  = state;
    ctl     = '0;
    lnc     = '0;
    has_req = trig || (pending != '0);
    case (state)
      IDLE: if (has_req) begin
        nstate = HIGH;
        lnc.go = 1'b1;
      end
      HIGH: if (zero) begin
        nstate   = LOW;
        ctl.load = 1'b1;
        ctl.val  = LO_LD;
      end else begin
        ctl.dec = 1'b1;
      end
      LOW: if (zero) begin
        if (has_req) begin
          nstate = HIGH;
          lnc.go = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end else begin
        ctl.dec = 1'b1;
      end
      default: nstate = IDLE;
    endcase
    // A queued request always wins the launch over a fresh trig.
    if (lnc.go) begin
      ctl.load      = 1'b1;
      ctl.val       = HI_LD;
      lnc.from_pend = (pending != '0);
    end
  end

  always_comb begin
    async_d = (nstate == HIGH) ? ACT : ~ACT;
    busy_d  = (nstate != IDLE);
  end

  assign inc  = trig && !(lnc.go && !lnc.from_pend);
  assign dec  = lnc.from_pend;
  assign full = &pending;

  // Outputs are registered off the next state so nothing from trig leaks out combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      async    <= ~ACT;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      async <= async_d;
      busy  <= busy_d;
      if (inc && !dec) begin
        if (full) overflow <= 1'b1;
        else      pending  <= pending + 1'b1;
      end else if (dec && !inc) begin
        pending <= pending - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_edgegen.sv
// Self-checking bench for edgegen: directed timing scenarios plus randomized
// traffic against a timestamp-based reference model, over four configurations.
module tb_edgegen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic [3:0] as_v, bz_v, ov_v;
  logic [3:0] p0, p1;
  logic [1:0] p2;
  logic [2:0] p3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  // model: per instance, start cycle of the last launch plus queue depth
  int HIv[4]  = '{4, 4, 4, 1};
  int LOv[4]  = '{4, 4, 4, 1};
  int PMX[4]  = '{15, 15, 3, 7};
  bit ACTv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int L[4]    = '{-1000, -1000, -1000, -1000};
  int pend[4] = '{0, 0, 0, 0};
  bit ovf[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  edgegen d0 (.clk(clk), .rst_n(rst_n), .trig(trig), .async(as_v[0]), .busy(bz_v[0]),
              .pending(p0), .overflow(ov_v[0]));
  edgegen #(.e("neg")) d1 (.clk(clk), .rst_n(rst_n), .trig(trig), .async(as_v[1]),
              .busy(bz_v[1]), .pending(p1), .overflow(ov_v[1]));
  edgegen #(.PW(2)) d2 (.clk(clk), .rst_n(rst_n), .trig(trig), .async(as_v[2]),
              .busy(bz_v[2]), .pending(p2), .overflow(ov_v[2]));
  edgegen #(.HI(1), .LO(1), .PW(3)) d3 (.clk(clk), .rst_n(rst_n), .trig(trig),
              .async(as_v[3]), .busy(bz_v[3]), .pending(p3), .overflow(ov_v[3]));

  function automatic int obs_p(input int i);
    case (i)
      0: return int'(p0);
      1: return int'(p1);
      2: return int'(p2);
      default: return int'(p3);
    endcase
  endfunction

  // Drive one cycle, advance the model across the edge, sample 1ns after it.
  task automatic step(input bit t, input bit r);
    trig  = t;
    rst_n = r;
    for (int i = 0; i < 4; i++) begin
      bit can, go, fp, inc;
      if (!r) begin
        L[i] = -1000; pend[i] = 0; ovf[i] = 1'b0;
      end else begin
        can = (cyc + 1 >= L[i] + HIv[i] + LOv[i]);
        go  = can && (t || pend[i] > 0);
        fp  = go && pend[i] > 0;
        inc = t && !(go && !fp);
        if (inc && !fp) begin
          if (pend[i] == PMX[i]) ovf[i] = 1'b1;
          else pend[i]++;
        end else if (fp && !inc) begin
          pend[i]--;
        end
        if (go) L[i] = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    repeat (2) step(1'($urandom % 2), 1'b0);
    base = cyc;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'($urandom % 2), 1'b0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (as_v[i] !== !ACTv[i] || bz_v[i] !== 1'b0 || obs_p(i) != 0 || ov_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset[%0d] got async=%b busy=%b pend=%0d ovf=%b exp async=%b busy=0 pend=0 ovf=0",
                   i, as_v[i], bz_v[i], obs_p(i), ov_v[i], !ACTv[i]);
        end
      end
    end
    base = cyc;
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 25; k++) begin
      int rel;
      bit ea, eb;
      step(1'((cyc - base) == 10), 1'b1);
      rel = cyc - base;
      ea = (rel >= 11 && rel <= 14);
      eb = (rel >= 11 && rel <= 18);
      checks += 3;
      if (as_v[0] !== ea) begin
        errors++; $display("FAIL single_pos cyc %0d got %b exp %b", rel, as_v[0], ea);
      end
      if (as_v[1] !== !ea) begin
        errors++; $display("FAIL single_neg cyc %0d got %b exp %b", rel, as_v[1], !ea);
      end
      if (bz_v[0] !== eb) begin
        errors++; $display("FAIL single_busy cyc %0d got %b exp %b", rel, bz_v[0], eb);
      end
    end
  endtask

  task automatic test_burst();
    int starts[$];
    int hi_cnt = 0, peak = 0, rel;
    bit prev = 1'b0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      rel = cyc - base;
      step(1'(rel >= 10 && rel <= 12), 1'b1);
      rel = cyc - base;
      if (as_v[0] && !prev) starts.push_back(rel);
      if (as_v[0]) hi_cnt++;
      prev = as_v[0];
      if (int'(p0) > peak) peak = int'(p0);
      if (rel == 28) begin
        checks++;
        if (p0 !== 4'd0) begin errors++; $display("FAIL burst_drain got %0d exp 0", p0); end
      end
    end
    checks += 3;
    if (peak != 2) begin errors++; $display("FAIL burst_peak got %0d exp 2", peak); end
    if (hi_cnt != 12) begin errors++; $display("FAIL burst_width got %0d exp 12", hi_cnt); end
    if (starts.size() != 3 || starts[0] != 11 || starts[1] != 19 || starts[2] != 27) begin
      errors++;
      $display("FAIL burst_starts got n=%0d first=%0d exp 11,19,27", starts.size(),
               (starts.size() > 0) ? starts[0] : -1);
    end
  endtask

  task automatic test_last_low();
    int rel;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      rel = cyc - base;
      step(1'(rel == 10 || rel == 18 || rel == 20 || rel == 26), 1'b1);
      rel = cyc - base;
      if (rel == 18 || rel == 19 || rel == 27) begin
        checks += 2;
        if (as_v[0] !== (rel != 18)) begin
          errors++; $display("FAIL lastlow_async cyc %0d got %b exp %b", rel, as_v[0], rel != 18);
        end
        if (int'(p0) != ((rel == 27) ? 1 : 0)) begin
          errors++; $display("FAIL lastlow_pend cyc %0d got %0d exp %0d", rel, p0, (rel == 27) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n0 = 0, n2 = 0, rel;
    bit pr0 = 1'b0, pr2 = 1'b0;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      rel = cyc - base;
      step(1'(rel >= 2 && rel <= 6), 1'b1);
      rel = cyc - base;
      if (as_v[0] && !pr0) n0++;
      if (as_v[2] && !pr2) n2++;
      pr0 = as_v[0]; pr2 = as_v[2];
      if (rel == 6 || rel == 7) begin
        checks += 2;
        if (p2 !== 2'd3) begin errors++; $display("FAIL ovf_sat cyc %0d got %0d exp 3", rel, p2); end
        if (ov_v[2] !== (rel == 7)) begin
          errors++; $display("FAIL ovf_set cyc %0d got %b exp %b", rel, ov_v[2], rel == 7);
        end
      end
    end
    checks += 4;
    if (n2 != 4) begin errors++; $display("FAIL ovf_pulses got %0d exp 4", n2); end
    if (ov_v[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ov_v[2]); end
    if (n0 != 5) begin errors++; $display("FAIL ovf_wide_pulses got %0d exp 5", n0); end
    if (ov_v[0] !== 1'b0) begin errors++; $display("FAIL ovf_wide_flag got %b exp 0", ov_v[0]); end
  endtask

  task automatic test_reset_mid();
    int rel, act = 0;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      rel = cyc - base;
      if (rel == 13) begin
        checks += 2;
        if (p0 !== 4'd2) begin errors++; $display("FAIL midrst_pre_pend got %0d exp 2", p0); end
        if (as_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre_async got %b exp 1", as_v[0]); end
      end
      step(1'(rel >= 10 && rel <= 12), 1'(rel != 13));
      rel = cyc - base;
      if (rel == 14) begin
        checks++;
        if (as_v[0] !== 1'b0 || as_v[1] !== 1'b1 || p0 !== 4'd0 || bz_v[0] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_post got async=%b/%b pend=%0d busy=%b exp 0/1 0 0",
                   as_v[0], as_v[1], p0, bz_v[0]);
        end
      end else if (rel > 14 && (as_v[0] || bz_v[0])) begin
        act++;
      end
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", act); end
  endtask

  task automatic test_random();
    int thr = 50;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) thr = $urandom_range(0, 100);
      step(1'(($urandom % 100) < thr), 1'(($urandom % 300) != 0));
      for (int i = 0; i < 4; i++) begin
        bit ea, eb;
        ea = (L[i] <= cyc && cyc < L[i] + HIv[i]) ? ACTv[i] : !ACTv[i];
        eb = (L[i] <= cyc && cyc < L[i] + HIv[i] + LOv[i]);
        checks++;
        if (as_v[i] !== ea || bz_v[i] !== eb || obs_p(i) != pend[i] || ov_v[i] !== ovf[i]) begin
          errors++;
          $display("FAIL rnd[%0d] cyc %0d got async=%b busy=%b pend=%0d ovf=%b exp %b %b %0d %b",
                   i, cyc, as_v[i], bz_v[i], obs_p(i), ov_v[i], ea, eb, pend[i], ovf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_last_low();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
